// File: rtl/decode_pkg.sv
// Shared definitions for the immediate-decode stage.
//  - RV32I major opcode constants (instr[6:0])
//  - 3-bit format codes carried on out_fmt
//  - state encoding for the main/skid handshake FSM
package decode_pkg;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_MISCMEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_OP      = 7'b0110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    // EMPTY: nothing held, FULL: main register held, SKID: main + skid held
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

endpackage

// File: rtl/imm_sel.sv
// Combinational immediate selector.
// Classifies an RV32I instruction by opcode and picks the matching
// per-format immediate (I/S/B/U/J), already shifted and sign-extended.
// Ports:
//  instr   in   32  raw instruction word
//  imm     out  32  selected immediate (0 for R-type and unknown opcodes)
//  fmt     out  3   format code (FMT_*)
//  illegal out  1   opcode outside the supported RV32I set
module imm_sel
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output logic [2:0]  fmt,
    output logic        illegal
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    // Per-format generators; B and J are halfword offsets so bit 0 is forced to 0
    always_comb begin
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'h000};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    // Opcode classification; unknown opcodes still pass through, flagged illegal
    always_comb begin
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OP_LUI, OP_AUIPC:                                   fmt = FMT_U;
            OP_JAL:                                             fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_OPIMM, OP_MISCMEM, OP_SYSTEM:  fmt = FMT_I;
            OP_STORE:                                           fmt = FMT_S;
            OP_BRANCH:                                          fmt = FMT_B;
            OP_OP:                                              fmt = FMT_NONE;
            default:                                            illegal = 1'b1;
        endcase
    end

    // 5-way immediate mux; NONE yields zero
    always_comb begin
        imm = 32'h0;
        case (fmt)
            FMT_I:   imm = imm_i;
            FMT_S:   imm = imm_s;
            FMT_B:   imm = imm_b;
            FMT_U:   imm = imm_u;
            FMT_J:   imm = imm_j;
            default: imm = 32'h0;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage between fetch and register-read.
// Each incoming instruction is decoded on entry and the decoded fields are
// stored in a 2-entry main/skid buffer, so the output path is register-only.
// in_ready comes straight from the state register and never from out_ready.
// Ports:
//  clk, rst             clock, asynchronous active-high reset
//  flush                discard held and incoming instructions this cycle
//  in_valid/in_ready    upstream handshake
//  in_instrn, in_tag    instruction word and sideband tag (PC)
//  out_valid/out_ready  downstream handshake
//  out_instrn, out_tag  passed-through instruction and tag
//  out_imm, out_fmt     decoded immediate and format code
//  out_illegal          opcode outside supported RV32I set
module imm_decode_stage
    import decode_pkg::*;
#(
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instrn,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instrn,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal
);

    state_t state;
    state_t next_state;

    logic [31:0]      dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_illegal;

    logic [31:0]      main_instrn;
    logic [TAG_W-1:0] main_tag;
    logic [31:0]      main_imm;
    logic [2:0]       main_fmt;
    logic             main_illegal;

    logic [31:0]      skid_instrn;
    logic [TAG_W-1:0] skid_tag;
    logic [31:0]      skid_imm;
    logic [2:0]       skid_fmt;
    logic             skid_illegal;

    logic accept;
    logic drain;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    imm_sel u_imm_sel (
        .instr   (in_instrn),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_ready    = (state != ST_SKID);
    assign out_valid   = (state != ST_EMPTY);
    assign accept      = in_valid & in_ready;
    assign drain       = out_valid & out_ready;

    assign out_instrn  = main_instrn;
    assign out_tag     = main_tag;
    assign out_imm     = main_imm;
    assign out_fmt     = main_fmt;
    assign out_illegal = main_illegal;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next state and buffer load controls; flush wins over accept and drain
    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        next_state   = ST_FULL;
                        load_main_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        next_state = ST_SKID;
                        load_skid  = 1'b1;
                    end else if (drain) begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drain) begin
                        next_state     = ST_FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    next_state = ST_EMPTY;
                end
            endcase
        end
    end

    // Main register: loaded from the decoder or promoted from the skid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_instrn  <= '0;
            main_tag     <= '0;
            main_imm     <= '0;
            main_fmt     <= FMT_NONE;
            main_illegal <= 1'b0;
        end else if (load_main_in) begin
            main_instrn  <= in_instrn;
            main_tag     <= in_tag;
            main_imm     <= dec_imm;
            main_fmt     <= dec_fmt;
            main_illegal <= dec_illegal;
        end else if (load_main_skid) begin
            main_instrn  <= skid_instrn;
            main_tag     <= skid_tag;
            main_imm     <= skid_imm;
            main_fmt     <= skid_fmt;
            main_illegal <= skid_illegal;
        end
    end

    // Skid register: catches the one instruction accepted while main is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_instrn  <= '0;
            skid_tag     <= '0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_illegal <= 1'b0;
        end else if (load_skid) begin
            skid_instrn  <= in_instrn;
            skid_tag     <= in_tag;
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed cases followed by a
// random valid/ready/flush run against a queue-based reference model.
module tb_imm_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] tag;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instrn;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instrn;
    logic [31:0] out_tag;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;
    entry_t model_q[$];
    logic [6:0] ops [11];

    imm_decode_stage #(.TAG_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instrn   (in_instrn),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instrn  (out_instrn),
        .out_tag     (out_tag),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode written as signed field arithmetic
    function automatic entry_t makeEntry(input logic [31:0] i, input logic [31:0] tg);
        entry_t e;
        int v;
        e.instr   = i;
        e.tag     = tg;
        e.imm     = 32'h0;
        e.fmt     = 3'd0;
        e.illegal = 1'b0;
        v = 0;
        case (i[6:0])
            7'h37, 7'h17: begin
                e.fmt = 3'd4;
                e.imm = 32'(int'(i[31:12]) * 4096);
            end
            7'h6F: begin
                e.fmt = 3'd5;
                v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2
                    - (i[31] ? 1048576 : 0);
                e.imm = 32'(v);
            end
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin
                e.fmt = 3'd1;
                v = int'(i[30:20]) - (i[31] ? 2048 : 0);
                e.imm = 32'(v);
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = int'(i[30:25]) * 32 + int'(i[11:7]) - (i[31] ? 2048 : 0);
                e.imm = 32'(v);
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2
                    - (i[31] ? 4096 : 0);
                e.imm = 32'(v);
            end
            7'h33: e.fmt = 3'd0;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then advance the model across the edge
    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                                 input logic rdy, input logic fl);
        int pre;
        in_valid  = v;
        in_instrn = ins;
        in_tag    = tg;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        pre = model_q.size();
        if (fl) begin
            model_q.delete();
        end else begin
            if (pre > 0 && rdy) void'(model_q.pop_front());
            if (v && pre < 2) model_q.push_back(makeEntry(ins, tg));
        end
        #1;
    endtask

    // Compare DUT outputs with the model's view of the buffer
    task automatic checkOutput(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() > 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            chk({tag, ".instrn"}, out_instrn, model_q[0].instr);
            chk({tag, ".tag"}, out_tag, model_q[0].tag);
            chk({tag, ".imm"}, out_imm, model_q[0].imm);
            chk({tag, ".fmt"}, 32'(out_fmt), 32'(model_q[0].fmt));
            chk({tag, ".illegal"}, 32'(out_illegal), 32'(model_q[0].illegal));
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [6:0]  op;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33};
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instrn = 32'h0;
        in_tag    = 32'h0;
        out_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_imm", out_imm, 32'h0);
        chk("rst.out_fmt", 32'(out_fmt), 32'd0);
        chk("rst.out_illegal", 32'(out_illegal), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed decodes with out_ready held high
        applyStimulus(1'b1, 32'h12345037, 32'h0000_1000, 1'b1, 1'b0);
        checkOutput("lui");
        chk("lui.imm_const", out_imm, 32'h12345000);
        chk("lui.fmt_const", 32'(out_fmt), 32'd4);
        applyStimulus(1'b1, 32'hFFF00093, 32'h0000_1004, 1'b1, 1'b0);
        checkOutput("addi");
        chk("addi.imm_const", out_imm, 32'hFFFFFFFF);
        applyStimulus(1'b1, 32'hFE20AE23, 32'h0000_1008, 1'b1, 1'b0);
        checkOutput("sw");
        chk("sw.imm_const", out_imm, 32'hFFFFFFFC);
        applyStimulus(1'b1, 32'h0080006F, 32'h0000_100C, 1'b1, 1'b0);
        checkOutput("jal");
        chk("jal.imm_const", out_imm, 32'h00000008);
        chk("jal.fmt_const", 32'(out_fmt), 32'd5);
        applyStimulus(1'b1, 32'h0000007F, 32'h0000_1010, 1'b1, 1'b0);
        checkOutput("illegal");
        chk("illegal.flag_const", 32'(out_illegal), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("drain0");

        // Back-pressure: A then B with out_ready low, then release
        applyStimulus(1'b1, 32'h00100093, 32'hAAAA_0000, 1'b0, 1'b0);
        checkOutput("bp.a");
        applyStimulus(1'b1, 32'h00208113, 32'hBBBB_0000, 1'b0, 1'b0);
        checkOutput("bp.b");
        chk("bp.in_ready_low", 32'(in_ready), 32'd0);
        chk("bp.hold_a", out_tag, 32'hAAAA_0000);
        applyStimulus(1'b1, 32'h00308193, 32'hCCCC_0000, 1'b0, 1'b0);
        checkOutput("bp.stall");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp.rel1");
        chk("bp.b_next", out_tag, 32'hBBBB_0000);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp.rel2");

        // Flush while SKID with an incoming instruction
        applyStimulus(1'b1, 32'h00100093, 32'hD000_0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h00100093, 32'hD000_0002, 1'b0, 1'b0);
        checkOutput("fl.skid");
        applyStimulus(1'b1, 32'h00100093, 32'hD000_0003, 1'b1, 1'b1);
        checkOutput("fl.after");
        chk("fl.out_valid0", 32'(out_valid), 32'd0);
        chk("fl.in_ready1", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("fl.quiet");

        // Asynchronous reset while FULL, checked before the next clock edge
        applyStimulus(1'b1, 32'h12345037, 32'hE000_0000, 1'b0, 1'b0);
        checkOutput("ar.full");
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        chk("ar.out_valid0", 32'(out_valid), 32'd0);
        chk("ar.out_imm0", out_imm, 32'h0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ar.post");

        // Random run against the reference model
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            if ($urandom_range(0, 9) == 0) op = 7'($urandom());
            else op = ops[$urandom_range(0, 10)];
            applyStimulus($urandom_range(0, 99) < 70, {r[31:7], op}, 32'(n),
                          $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
            checkOutput("rand");
        end
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checkOutput("final");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
